gemm_outer_array: RTL and testbench

Parametrised successor to the linear GEMM PE chain: a C_NUM_PE x C_DIM grid of multiply-accumulate cells that computes one output tile C = A·B as a sum of outer products. Per input beat it takes one A column (C_NUM_PE words) and one B row (C_DIM words). A tile is closed by a last flag; the block then drains the tile one row per beat over a ready/valid output port. It sits between the operand streamers and the result writer. Unlike the chained PEs, it adds:

- full backpressure on both ports;
- configurable accumulator width and signedness;
- tile framing.

---
 rtl/gemm_outer_array.sv | 131 +++++++++++++
 tb/tb_gemm_outer_array.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_outer_array.sv
// Outer-product GEMM tile engine: a C_NUM_PE x C_DIM grid of MAC cells fed one
// A column and one B row per beat, then drained one accumulator row per beat.
module gemm_outer_array #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_PE     = 4,
  parameter int C_DIM        = 4,
  parameter int C_ACC_WIDTH  = 48,
  parameter int C_SIGNED     = 1,
  parameter int C_BEAT_WIDTH = 16,
  localparam int ROW_W = (C_NUM_PE > 1) ? $clog2(C_NUM_PE) : 1
) (
  input  logic                           clock,
  input  logic                           i_reset,
  input  logic [C_NUM_PE*C_DATA_WIDTH-1:0] Ain_data,
  input  logic [C_DIM*C_DATA_WIDTH-1:0]  Bin_data,
  input  logic                           i_in_valid,
  input  logic                           i_in_last,
  output logic                           o_in_ready,
  output logic [C_DIM*C_ACC_WIDTH-1:0]   o_out_data,
  output logic [ROW_W-1:0]               o_out_row,
  output logic                           o_out_valid,
  output logic                           o_out_last,
  input  logic                           i_out_ready,
  output logic [C_BEAT_WIDTH-1:0]        o_beats
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // o_in_ready and o_out_valid come straight from the state register, so
  // neither depends combinationally on the opposite side's valid/ready.

  localparam int W  = C_DATA_WIDTH;
  localparam int PW = (C_ACC_WIDTH > 2*W+2) ? C_ACC_WIDTH : 2*W+2;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(C_NUM_PE-1);

  typedef enum logic {ST_ACC, ST_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic                     first_q, first_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [C_BEAT_WIDTH-1:0]  beats_q, beats_d;
  logic [C_ACC_WIDTH-1:0]   acc_q [C_NUM_PE][C_DIM];
  logic                     in_fire, out_fire;

  // Operands get one extra bit (sign or zero) so a single signed multiply
  // covers both signedness modes; the low C_ACC_WIDTH bits are the extension.
  function automatic logic [C_ACC_WIDTH-1:0] mac_prod(input logic [W-1:0] a,
                                                      input logic [W-1:0] b);
    logic signed [W:0]    ae, be;
    logic signed [PW-1:0] pf;
    ae = {(C_SIGNED != 0) & a[W-1], a};
    be = {(C_SIGNED != 0) & b[W-1], b};
    pf = PW'(ae) * PW'(be);
    return pf[C_ACC_WIDTH-1:0];
  endfunction

  assign o_in_ready  = (state_q == ST_ACC);
  assign o_out_valid = (state_q == ST_DRAIN);
  assign o_out_last  = o_out_valid && (row_q == LAST_ROW);
  assign o_out_row   = row_q;
  assign o_beats     = beats_q;
  assign in_fire     = i_in_valid && o_in_ready;
  assign out_fire    = o_out_valid && i_out_ready;

  always_comb begin
    o_out_data = '0;
    for (int j = 0; j < C_DIM; j++) begin
      o_out_data[j*C_ACC_WIDTH +: C_ACC_WIDTH] = acc_q[row_q][j];
    end
  end

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    row_d   = row_q;
    beats_d = beats_q;
    case (state_q)
      ST_ACC: begin
        if (in_fire) begin
          first_d = 1'b0;
          beats_d = first_q ? C_BEAT_WIDTH'(1) : beats_q + C_BEAT_WIDTH'(1);
          if (i_in_last) begin
            state_d = ST_DRAIN;
            row_d   = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (out_fire) begin
          if (row_q == LAST_ROW) begin
            state_d = ST_ACC;
            row_d   = '0;
            first_d = 1'b1;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= ST_ACC;
      first_q <= 1'b1;
      row_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      row_q   <= row_d;
      beats_q <= beats_d;
    end
  end

  // Accumulators carry no reset; the first flag makes stale contents irrelevant.
  always_ff @(posedge clock) begin
    if (in_fire) begin
      for (int i = 0; i < C_NUM_PE; i++) begin
        for (int j = 0; j < C_DIM; j++) begin
          if (first_q) begin
            acc_q[i][j] <= mac_prod(Ain_data[i*W +: W], Bin_data[j*W +: W]);
          end else begin
            acc_q[i][j] <= acc_q[i][j] + mac_prod(Ain_data[i*W +: W], Bin_data[j*W +: W]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gemm_outer_array.sv
// Bench for gemm_outer_array in a 2x2, 8-bit signed, 20-bit accumulator setup.
module tb_gemm_outer_array;

  localparam int W   = 8;
  localparam int NPE = 2;
  localparam int DIM = 2;
  localparam int AW  = 20;
  localparam int BW  = 16;

  logic                clock = 1'b0;
  logic                i_reset = 1'b1;
  logic [NPE*W-1:0]    Ain_data = '0;
  logic [DIM*W-1:0]    Bin_data = '0;
  logic                i_in_valid = 1'b0;
  logic                i_in_last = 1'b0;
  logic                o_in_ready;
  logic [DIM*AW-1:0]   o_out_data;
  logic [0:0]          o_out_row;
  logic                o_out_valid;
  logic                o_out_last;
  logic                i_out_ready = 1'b0;
  logic [BW-1:0]       o_beats;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DIM*AW-1:0] exp_q[$];
  longint            m_acc[NPE][DIM];
  bit                m_first = 1'b1;
  int                m_beats = 0;

  gemm_outer_array #(
    .C_DATA_WIDTH(W), .C_NUM_PE(NPE), .C_DIM(DIM),
    .C_ACC_WIDTH(AW), .C_SIGNED(1), .C_BEAT_WIDTH(BW)
  ) dut (
    .clock(clock), .i_reset(i_reset),
    .Ain_data(Ain_data), .Bin_data(Bin_data),
    .i_in_valid(i_in_valid), .i_in_last(i_in_last), .o_in_ready(o_in_ready),
    .o_out_data(o_out_data), .o_out_row(o_out_row), .o_out_valid(o_out_valid),
    .o_out_last(o_out_last), .i_out_ready(i_out_ready), .o_beats(o_beats)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one beat, wait for acceptance, update the reference model.
  task automatic send_beat(input int a0, input int a1, input int b0, input int b1, input bit last);
    int av[2];
    int bv[2];
    int guard;
    longint p;
    logic [DIM*AW-1:0] r;
    av = '{a0, a1};
    bv = '{b0, b1};
    Ain_data   = {8'(a1), 8'(a0)};
    Bin_data   = {8'(b1), 8'(b0)};
    i_in_valid = 1'b1;
    i_in_last  = last;
    guard = 0;
    while (!o_in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!o_in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_timeout: o_in_ready=%b required 1", o_in_ready);
      i_in_valid = 1'b0;
      return;
    end
    tick();
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
    for (int i = 0; i < NPE; i++) begin
      for (int j = 0; j < DIM; j++) begin
        p = longint'(av[i]) * longint'(bv[j]);
        m_acc[i][j] = m_first ? p : m_acc[i][j] + p;
      end
    end
    m_beats = m_first ? 1 : m_beats + 1;
    m_first = 1'b0;
    n_checks++;
    if (o_beats !== BW'(m_beats)) begin
      n_fail++;
      $display("FAIL beats: got %0d required %0d", o_beats, m_beats);
    end
    if (last) begin
      for (int i = 0; i < NPE; i++) begin
        for (int j = 0; j < DIM; j++) r[j*AW +: AW] = AW'(m_acc[i][j]);
        exp_q.push_back(r);
      end
      m_first = 1'b1;
      n_checks++;
      if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_latency: valid=%b ready=%b required valid=1 ready=0", o_out_valid, o_in_ready);
      end
    end
  endtask

  // Consume nrows output rows, stalling stall0 cycles on row 0.
  task automatic drain(input int stall0, input int nrows, output int busy_cnt);
    logic [DIM*AW-1:0] exp_row;
    int guard;
    busy_cnt = 0;
    for (int r = 0; r < nrows; r++) begin
      guard = 0;
      while (!o_out_valid && guard < 50) begin
        tick();
        guard++;
      end
      n_checks++;
      if (!o_out_valid || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_valid_timeout: valid=%b queued=%0d", o_out_valid, exp_q.size());
        return;
      end
      exp_row = exp_q.pop_front();
      n_checks++;
      if (o_out_row !== 1'(r) || o_out_last !== (r == NPE-1)) begin
        n_fail++;
        $display("FAIL row_tag: row=%0d last=%b required row=%0d last=%b", o_out_row, o_out_last, r, (r == NPE-1));
      end
      n_checks++;
      if (o_out_data !== exp_row) begin
        n_fail++;
        $display("FAIL row_data r%0d: got %h required %h", r, o_out_data, exp_row);
      end
      if (!o_in_ready) busy_cnt++;
      if (r == 0) begin
        for (int s = 0; s < stall0; s++) begin
          i_in_valid = ~i_in_valid;
          i_in_last  = 1'b1;
          Ain_data   = NPE*W'($urandom_range(0, 65535));
          Bin_data   = DIM*W'($urandom_range(0, 65535));
          tick();
          n_checks++;
          if (o_out_data !== exp_row || o_out_row !== 1'b0 || o_out_valid !== 1'b1 ||
              o_in_ready !== 1'b0 || o_beats !== BW'(m_beats)) begin
            n_fail++;
            $display("FAIL stall_hold s%0d: data=%h row=%0d valid=%b rdy=%b beats=%0d required data=%h row=0 valid=1 rdy=0 beats=%0d",
                     s, o_out_data, o_out_row, o_out_valid, o_in_ready, o_beats, exp_row, m_beats);
          end
        end
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
      end
      i_out_ready = 1'b1;
      tick();
      i_out_ready = 1'b0;
    end
    if (nrows == NPE) begin
      n_checks++;
      if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL tile_end: rdy=%b valid=%b required rdy=1 valid=0", o_in_ready, o_out_valid);
      end
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_out_last !== 1'b0 ||
        o_out_row !== 1'b0 || o_beats !== '0) begin
      n_fail++;
      $display("FAIL reset_held: rdy=%b valid=%b last=%b row=%0d beats=%0d required 1 0 0 0 0",
               o_in_ready, o_out_valid, o_out_last, o_out_row, o_beats);
    end
    i_reset = 1'b0;
    tick();
    n_checks++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_out_last !== 1'b0 ||
        o_out_row !== 1'b0 || o_beats !== '0) begin
      n_fail++;
      $display("FAIL reset_after: rdy=%b valid=%b last=%b row=%0d beats=%0d required 1 0 0 0 0",
               o_in_ready, o_out_valid, o_out_last, o_out_row, o_beats);
    end
    m_first = 1'b1;
    m_beats = 0;
  endtask

  task automatic test_single_beat();
    int busy;
    send_beat(3, -2, 4, 5, 1'b1);
    drain(0, NPE, busy);
  endtask

  task automatic test_gapped_beats();
    int busy;
    send_beat(1, 1, 2, 3, 1'b0);
    tick(); tick();
    send_beat(1, 1, 2, 3, 1'b0);
    tick();
    send_beat(1, 1, 2, 3, 1'b1);
    drain(0, NPE, busy);
    n_checks++;
    if (busy != NPE) begin
      n_fail++;
      $display("FAIL in_ready_low_cycles: got %0d required %0d", busy, NPE);
    end
  endtask

  task automatic test_backpressure();
    int busy;
    send_beat(7, -1, -3, 2, 1'b1);
    drain(5, NPE, busy);
  endtask

  task automatic test_back_to_back();
    int busy;
    send_beat(5, 5, 5, 5, 1'b1);
    drain(0, NPE, busy);
    send_beat(1, 2, 3, 4, 1'b1);
    drain(0, NPE, busy);
  endtask

  task automatic test_wrap();
    int busy;
    for (int k = 0; k < 64; k++) send_beat(-128, -128, -128, -128, k == 63);
    n_checks++;
    if (o_beats !== BW'(64)) begin
      n_fail++;
      $display("FAIL wrap_beats: got %0d required 64", o_beats);
    end
    drain(0, NPE, busy);
  endtask

  task automatic test_reset_mid_drain();
    int busy;
    logic [DIM*AW-1:0] dropped;
    send_beat(2, 3, 1, 1, 1'b1);
    drain(0, 1, busy);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    dropped = exp_q.pop_front();
    m_first = 1'b1;
    m_beats = 0;
    n_checks++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_beats !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_drain: valid=%b rdy=%b beats=%0d required 0 1 0 (dropped row %h)",
               o_out_valid, o_in_ready, o_beats, dropped);
    end
    send_beat(1, 1, 1, 1, 1'b1);
    drain(0, NPE, busy);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_gapped_beats();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid_drain();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_rows: got %0d required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
